// File: rtl/seq_adder_pkg.sv
// Shared definitions for seq_adder: FSM state encoding and parameter legality check.
// Optional feature macro used by seq_adder: SEQ_ADDER_SUB_EN (subtract mode).
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // DIGIT must be non-zero and evenly divide WIDTH.
  function automatic bit digit_legal(input int width, input int digit);
    return (digit > 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/seq_adder_add_slice.sv
// add_slice: DIGIT-bit combinational ripple-carry adder, one slice of seq_adder.
module add_slice #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic w_c;

  always_comb begin
    // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
    sum = '0;
    w_c = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i] = x[i] ^ y[i] ^ w_c;
      w_c    = (x[i] & y[i]) | (w_c & (x[i] ^ y[i]));
    end
    cout = w_c;
  end

endmodule

// File: rtl/seq_adder.sv
// seq_adder: digit-serial adder, DIGIT bits per clock, valid/ready on both sides.
// Define SEQ_ADDER_SUB_EN to enable subtract mode (b replaced by ~b when sub=1).
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (!digit_legal(WIDTH, DIGIT)) begin : g_bad_params
      $error("seq_adder: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  state_t             r_state, w_state_next;
  logic [WIDTH-1:0]   r_xs, r_ys, r_acc, r_s;
  logic               r_carry, r_a_msb, r_b_msb, r_co, r_ovf;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   w_b_eff, w_acc_next;
  logic [DIGIT-1:0]   w_sum;
  logic               w_cout, w_last, w_accept;

`ifdef SEQ_ADDER_SUB_EN
  assign w_b_eff = sub ? ~b : b;
`else
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_b_eff      = b;
`endif

  assign w_last   = (r_cnt == CNT_W'(NSLICE - 1));
  assign w_accept = (r_state == IDLE) && in_valid;

  add_slice #(.DIGIT(DIGIT)) u_add_slice (
    .x    (r_xs[DIGIT-1:0]),
    .y    (r_ys[DIGIT-1:0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Sum bits enter at the top of the accumulator; after NSLICE shifts it holds the full result.
  always_comb begin
    w_acc_next                    = r_acc >> DIGIT;
    w_acc_next[WIDTH-1 -: DIGIT]  = w_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN:  if (w_last) w_state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so outputs and internal carry read 0 straight out of reset.
    if (!rst_n) begin
      r_xs    <= '0;
      r_ys    <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_xs    <= a;
      r_ys    <= w_b_eff;
      r_acc   <= '0;
      r_carry <= ci;
      r_cnt   <= '0;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= w_b_eff[WIDTH-1];
    end else if (r_state == RUN) begin
      r_xs    <= r_xs >> DIGIT;
      r_ys    <= r_ys >> DIGIT;
      r_acc   <= w_acc_next;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      // Results only update on the final slice so s/co/ovf hold their old values until DONE.
      if (w_last) begin
        r_s   <= w_acc_next;
        r_co  <= w_cout;
        r_ovf <= (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign s   = r_s;
  assign co  = r_co;
  assign ovf = r_ovf;

endmodule
